// File: rtl/increment_pkg.sv
// increment_pkg: shared definitions for the lab counter increment scheduler.
//   - state_e       : controller state encoding (IDLE/RUN/RECFG)
//   - STEP_W        : width of the step value driven to the counter
//   - MAX_VAL       : counter wrap bound; larger steps are refused
//   - DEFAULT_STEP  : step value loaded at reset
//   - step_legal()  : true when a requested step may be applied
package increment_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RECFG = 2'd2
  } state_e;

  localparam int STEP_W       = 11;
  localparam int MAX_VAL      = 20;
  localparam int DEFAULT_STEP = 1;

  // A step of zero would stall the counter and a step beyond the wrap
  // bound would skip past it, so both are refused.
  function automatic logic step_legal(input logic [31:0] step,
                                      input int unsigned max_val);
    return (step != 32'd0) && (step <= max_val);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: brings the raw push button into the clk domain and turns
// each press into a single-cycle request.
//   clk    : system clock
//   rst    : synchronous active-low reset
//   btn_i  : raw asynchronous button level
//   rise_o : registered one-cycle pulse, high 3 clocks after a btn rise
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // sync1/sync2 form the metastability chain; prev holds the previous
  // synchronised level so a held button yields exactly one pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/increment_sched.sv
// increment_sched: sequences the lab counter. Produces the single-cycle
// increment pulse from a programmable auto-tick and a manual button, and
// owns the counter step configuration.
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   start     : level, IDLE -> RUN
//   stop      : level, back to IDLE (highest priority)
//   btn       : raw asynchronous manual-increment button
//   cfg_valid : new step offered
//   cfg_step  : offered step, captured when the offer is taken
//   cfg_ready : one-cycle acknowledge of a consumed offer
//   cfg_err   : last offer refused; sticky until an offer is accepted
//   signal    : one-cycle increment pulse to the counter
//   step_out  : current step to the counter
//   cnt_rst   : active-high counter reset
//   busy      : controller is not IDLE
//
// Config handshake: the sender raises cfg_valid with cfg_step stable and
// holds both until it sees cfg_ready high for one cycle. The offer is taken
// on the edge that enters RECFG (cfg_ready is high during RECFG); cfg_valid
// is ignored during RECFG itself. An offer coinciding with stop is not
// taken and stays pending for the next cycle.
module increment_sched #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int          STEP_W       = increment_pkg::STEP_W,
  parameter int unsigned MAX_VAL      = increment_pkg::MAX_VAL,
  parameter int          DEFAULT_STEP = increment_pkg::DEFAULT_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              btn,
  input  logic              cfg_valid,
  input  logic [STEP_W-1:0] cfg_step,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              signal,
  output logic [STEP_W-1:0] step_out,
  output logic              cnt_rst,
  output logic              busy
);

  import increment_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  // With a divide of one the tick never leaves a free slot, so a second
  // request in the same cycle cannot be queued.
  localparam logic PEND_EN = (TICK_DIV > 1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              pend_q, pend_d;
  logic              signal_q, signal_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cnt_rst_q, cnt_rst_d;
  logic              busy_q, busy_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] step_lat_q, step_lat_d;
  logic              man_req;
  logic              tick;

  btn_edge_sync u_btn_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .rise_o (man_req)
  );

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    presc_d     = presc_q;
    pend_d      = pend_q;
    signal_d    = 1'b0;
    cfg_ready_d = 1'b0;
    cfg_err_d   = cfg_err_q;
    cnt_rst_d   = 1'b0;
    step_d      = step_q;
    step_lat_d  = step_lat_q;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        pend_d  = 1'b0;
        if (stop) begin
          state_d = IDLE;
        end else if (cfg_valid) begin
          // cfg_ready and cnt_rst must be visible during RECFG, so the
          // verdict is taken from cfg_step on the entry edge.
          state_d     = RECFG;
          ret_d       = IDLE;
          step_lat_d  = cfg_step;
          cfg_ready_d = 1'b1;
          cnt_rst_d   = step_legal(32'(cfg_step), MAX_VAL);
        end else if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          presc_d = '0;
          pend_d  = 1'b0;
        end else if (cfg_valid) begin
          // No pulse on this edge: it would land in the cnt_rst cycle.
          state_d     = RECFG;
          ret_d       = RUN;
          step_lat_d  = cfg_step;
          cfg_ready_d = 1'b1;
          cnt_rst_d   = step_legal(32'(cfg_step), MAX_VAL);
          presc_d     = '0;
          pend_d      = 1'b0;
        end else begin
          signal_d = tick | man_req | pend_q;
          pend_d   = PEND_EN & tick & man_req;
          presc_d  = tick ? '0 : presc_q + PW'(1);
        end
      end

      RECFG: begin
        state_d = ret_q;
        presc_d = '0;
        pend_d  = 1'b0;
        if (step_legal(32'(step_lat_q), MAX_VAL)) begin
          step_d    = step_lat_q;
          cfg_err_d = 1'b0;
        end else begin
          cfg_err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
        pend_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      presc_q     <= '0;
      pend_q      <= 1'b0;
      signal_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      step_q      <= STEP_W'(DEFAULT_STEP);
      step_lat_q  <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      signal_q    <= signal_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      cnt_rst_q   <= cnt_rst_d;
      busy_q      <= busy_d;
      step_q      <= step_d;
      step_lat_q  <= step_lat_d;
    end
  end

  assign signal    = signal_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign cnt_rst   = cnt_rst_q;
  assign busy      = busy_q;
  assign step_out  = step_q;

endmodule

// File: doc/increment_sched.md
Name: increment_sched

Overview:
Controller that sequences the lab counter datapath. It generates the single-cycle increment `signal` from a programmable auto-tick and from a synchronised manual button, and merges the two so neither is lost. It also owns the counter's step configuration through a valid/ready handshake, resetting the counter on every accepted step change. It sits between board I/O (buttons, switches) and the counter instance.

Parameters:
TICK_DIV, 100000000, auto-tick period in clk cycles (1 s at 100 MHz); legal range >= 1
STEP_W, 11, width of step value
MAX_VAL, 20, counter wrap bound; a step above this is rejected
DEFAULT_STEP, 1, step value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (reset when 0 at posedge clk)
start  in  1  level; enter RUN from IDLE
stop  in  1  level; return to IDLE
btn  in  1  raw asynchronous manual-increment button
cfg_valid  in  1  new step offered
cfg_step  in  STEP_W  step value, sampled when cfg_valid accepted
cfg_ready  out  1  one-cycle acknowledge of a consumed cfg
cfg_err  out  1  last cfg rejected; sticky until next accepted cfg
signal  out  1  one-cycle increment pulse to counter
step_out  out  STEP_W  current step driven to counter
cnt_rst  out  1  active-high reset to counter
busy  out  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-low on rst; no asynchronous logic apart from the btn synchroniser input.
- Reset values: state IDLE, signal 0, step_out DEFAULT_STEP, cnt_rst 1 (held high throughout reset), cfg_ready 0, cfg_err 0, busy 0, prescaler 0, pending 0, synchroniser flops 0.
- First cycle after reset releases: cnt_rst drops to 0.
- All outputs are registered.
- btn path: 2-FF synchroniser, then rising-edge detect. The man_req pulse is internal, one cycle, 3 clks after the btn rise. Holding btn gives exactly one request.
- States: IDLE, RUN, RECFG.
- Priority each cycle: stop > cfg_valid > start.
- IDLE:
  - no signal pulses; man_req discarded; prescaler held at 0.
  - start -> RUN.
  - cfg_valid -> RECFG, with return state IDLE.
- RUN:
  - prescaler counts 0..TICK_DIV-1, then wraps; tick asserts when the prescaler equals TICK_DIV-1.
  - signal is asserted the cycle after any of tick, man_req or pending. At most one pulse per cycle.
  - tick and man_req in the same cycle: one pulse plus pending <= 1; the second pulse follows on the next cycle.
  - stop -> IDLE; prescaler and pending cleared; a queued pending pulse is dropped.
  - cfg_valid -> RECFG, with return state RUN.
- RECFG (exactly one cycle):
  - cfg_ready = 1 in this cycle; cfg_step was latched on the entry edge.
  - Rejected if step == 0 or step > MAX_VAL: cfg_err <= 1, step_out unchanged, no cnt_rst.
  - Otherwise accepted: step_out <= latched step, cnt_rst = 1 for this one cycle, cfg_err <= 0.
  - Both cases: prescaler and pending cleared, man_req ignored, then return to the saved state.
- Invariant: signal is never 1 in the same cycle as cnt_rst.
- stop together with cfg_valid: stop wins. The cfg is not consumed (no cfg_ready); the sender keeps cfg_valid high and it is taken in IDLE next cycle.
- Reset mid-operation (any state, including RECFG): all registers return to reset values; a half-done cfg is lost and cfg_ready is not issued.
- TICK_DIV == 1: tick every RUN cycle, signal held high continuously. Manual requests are dropped in this case, since no pending slot ever frees.
- Prescaler width: clog2(TICK_DIV), minimum 1 bit.

Decomposition:
- Package increment_pkg holds:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, RECFG = 2'd2)
  - STEP_W
  - MAX_VAL and DEFAULT_STEP defaults
  - a step-legality check function (step != 0 && step <= MAX_VAL)
- One sub-module, btn_edge_sync: 2-FF synchroniser plus rising-edge detector with the same clk/rst. The FSM, prescaler and pending logic stay in increment_sched.

Test Plan:
1. Reset/idle: hold rst=0 for 3 cycles, then release with TICK_DIV=4 and start=0 for 20 cycles. Expect step_out=1, cnt_rst=1 during reset then 0, signal never 1, busy=0.
2. Auto-tick: start=1 with TICK_DIV=4. Expect signal pulses exactly every 4 cycles, first pulse 5 cycles after RUN entry, busy=1. Then stop=1: no further pulses.
3. Collision: in RUN, time the btn rise so man_req coincides with a tick. Expect signal high on 2 consecutive cycles, then 4-cycle tick spacing resumes.
4. Valid cfg: in RUN, cfg_valid=1 with cfg_step=5 for one cycle. Expect cfg_ready and cnt_rst high for the same single cycle, step_out=5 afterwards, cfg_err=0, return to RUN, next tick 5 cycles later.
5. Invalid cfg: cfg_step=0, then cfg_step=21. Each gives cfg_ready one cycle, cfg_err=1, step_out unchanged, cnt_rst stays 0. A following cfg_step=2 clears cfg_err.
6. Priority/reset: stop and cfg_valid together in RUN give IDLE and no cfg_ready, then cfg accepted next cycle. Separately, asserting rst=0 during RECFG leaves step_out=1, cfg_ready=0 and state IDLE.
